proj_extender_ctrl: RTL and testbench

PROJ_EXTENDER_CTRL -- requirements
Module: proj_extender_ctrl

---
 rtl/proj_pkg.sv | 27 ++
 rtl/proj_wrap_counter.sv | 39 +++
 rtl/proj_extender_ctrl.sv | 130 +++++++++++++
 tb/tb_proj_extender_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared parameters, state type and width helpers for the fragment extender datapath.
package proj_pkg;

  localparam int FM_EXTENDER_FRAG_LEN_BITS     = 16;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int INDICE_LEN                    = 8;
  localparam int EXTENDER_OUT_PART_LEN         = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ext_ctrl_state_t;

  function automatic int parts_count(input int frag_bits, input int part_bits);
    return frag_bits / part_bits;
  endfunction

  // Counter width; a modulus of 1 still gets a 1-bit counter that never leaves 0.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

  function automatic int num_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/proj_wrap_counter.sv
// Modulo-N up counter with synchronous clear (priority) and enable; wrap_o flags the last count.
module proj_wrap_counter #(
  parameter int MODULUS = 4,
  parameter int WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign wrap_o = (cnt_q == WIDTH'(MODULUS - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/proj_extender_ctrl.sv
// Streams a batch of k-mer indices, each paired with every FRAG_PART-wide slice of the fragment,
// as valid/ready beats (index-major, part-minor) with position flags and an end-of-batch pulse.
module proj_extender_ctrl
  import proj_pkg::*;
#(
  parameter int FRAG_LEN_BITS = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
  parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
  parameter int FRAG_PART     = proj_pkg::EXTENDER_OUT_PART_LEN,
  localparam int PARTS_COUNT  = parts_count(FRAG_LEN_BITS, FRAG_PART),
  localparam int PART_W       = cnt_width(PARTS_COUNT),
  localparam int IDX_W        = cnt_width(INDICES_COUNT),
  localparam int NUM_W        = num_width(INDICES_COUNT)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [FRAG_LEN_BITS-1:0]                in_fragment,
  input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_kmer_indices,
  input  logic [NUM_W-1:0]                        in_num_indices,
  input  logic                                    abort,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [FRAG_PART-1:0]                    out_frag_part,
  output logic [INDICE_LEN-1:0]                   out_index,
  output logic [PART_W-1:0]                       out_part_idx,
  output logic                                    out_first_part,
  output logic                                    out_last_part,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    done
);

  ext_ctrl_state_t                         state_q, state_d;
  logic [FRAG_LEN_BITS-1:0]                frag_q, frag_d;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] idx_mem_q, idx_mem_d;
  logic [NUM_W-1:0]                        count_q, count_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic                                    done_q, done_d;

  logic              stream_s;
  logic              hs_s;
  logic              last_idx_s;
  logic              fin_s;
  logic              accept_s;
  logic [NUM_W-1:0]  num_sat_s;
  logic [PART_W-1:0] part_cnt_s;
  logic              part_wrap_s;

  assign stream_s   = (state_q == STREAM);
  assign hs_s       = stream_s & out_ready;
  assign last_idx_s = ((NUM_W'(idx_q) + NUM_W'(1)) == count_q);
  assign fin_s      = hs_s & part_wrap_s & last_idx_s;
  // A new batch may land on the final handshake so the stream continues without a bubble.
  assign in_ready   = ~abort & (~stream_s | fin_s);
  assign accept_s   = in_valid & in_ready;
  assign num_sat_s  = (in_num_indices > NUM_W'(INDICES_COUNT)) ? NUM_W'(INDICES_COUNT)
                                                               : in_num_indices;

  proj_wrap_counter #(
    .MODULUS (PARTS_COUNT),
    .WIDTH   (PART_W)
  ) u_part_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (abort | accept_s),
    .en_i    (hs_s),
    .cnt_o   (part_cnt_s),
    .wrap_o  (part_wrap_s)
  );

  always_comb begin
    state_d   = state_q;
    frag_d    = frag_q;
    idx_mem_d = idx_mem_q;
    count_d   = count_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (accept_s) begin
      frag_d    = in_fragment;
      idx_mem_d = in_kmer_indices;
      count_d   = num_sat_s;
      idx_d     = '0;
      state_d   = (num_sat_s != NUM_W'(0)) ? STREAM : IDLE;
      done_d    = fin_s | (num_sat_s == NUM_W'(0));
    end else if (fin_s) begin
      state_d = IDLE;
      idx_d   = '0;
      done_d  = 1'b1;
    end else if (hs_s && part_wrap_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frag_q    <= '0;
      idx_mem_q <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frag_q    <= frag_d;
      idx_mem_q <= idx_mem_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  // Flags are gated by out_valid so they read zero while idle and in reset.
  assign out_valid      = stream_s;
  assign busy           = stream_s;
  assign done           = done_q;
  assign out_frag_part  = frag_q[FRAG_PART*int'(part_cnt_s) +: FRAG_PART];
  assign out_index      = idx_mem_q[idx_q];
  assign out_part_idx   = part_cnt_s;
  assign out_first_part = stream_s & (part_cnt_s == PART_W'(0));
  assign out_last_part  = stream_s & part_wrap_s;
  assign out_last       = stream_s & part_wrap_s & last_idx_s;

endmodule

// File: tb/tb_proj_extender_ctrl.sv
// Self-checking bench: a batch-level queue model predicts every beat, plus directed literal checks.
module tb_proj_extender_ctrl;

  localparam int FLB = 16;
  localparam int FP  = 4;
  localparam int IC  = 4;
  localparam int IL  = 8;
  localparam int P   = FLB / FP;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, abort, out_valid, out_ready;
  logic out_first_part, out_last_part, out_last, busy, done;
  logic [FLB-1:0]         in_fragment;
  logic [IC-1:0][IL-1:0]  in_kmer_indices;
  logic [2:0]             in_num_indices;
  logic [FP-1:0]          out_frag_part;
  logic [IL-1:0]          out_index;
  logic [1:0]             out_part_idx;

  always #5 clk = ~clk;

  proj_extender_ctrl #(
    .FRAG_LEN_BITS (FLB),
    .INDICES_COUNT (IC),
    .INDICE_LEN    (IL),
    .FRAG_PART     (FP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_fragment     (in_fragment),
    .in_kmer_indices (in_kmer_indices),
    .in_num_indices  (in_num_indices),
    .abort           (abort),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_frag_part   (out_frag_part),
    .out_index       (out_index),
    .out_part_idx    (out_part_idx),
    .out_first_part  (out_first_part),
    .out_last_part   (out_last_part),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    logic [FP-1:0] frag;
    logic [IL-1:0] index;
    logic [1:0]    pidx;
    logic          first;
    logic          lastp;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  bit    exp_done = 1'b0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // The pending beats of the current batch live in exp_q; exactly one left means the last beat.
  function automatic bit model_ready();
    return !abort && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      bit    rdy;
      bit    nd;
      int    n;
      beat_t b;
      rdy = model_ready();
      nd  = 1'b0;
      if (abort) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) nd = 1'b1;
        end
        if (in_valid && rdy) begin
          n = (in_num_indices > IC) ? IC : int'(in_num_indices);
          acc_cyc = cyc;
          if (n == 0) nd = 1'b1;
          for (int i = 0; i < n; i++) begin
            for (int p = 0; p < P; p++) begin
              b.frag  = in_fragment[p*FP +: FP];
              b.index = in_kmer_indices[i];
              b.pidx  = 2'(p);
              b.first = (p == 0);
              b.lastp = (p == P - 1);
              b.last  = (p == P - 1) && (i == n - 1);
              b.cyc   = 0;
              exp_q.push_back(b);
            end
          end
        end
      end
      exp_done = nd;
    end
  end

  always @(negedge clk) begin
    beat_t b;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("busy", busy, exp_q.size() > 0);
    check("done", done, exp_done);
    check("in_ready", in_ready, model_ready());
    if (exp_q.size() > 0) begin
      check("out_frag_part", out_frag_part, exp_q[0].frag);
      check("out_index", out_index, exp_q[0].index);
      check("out_part_idx", out_part_idx, exp_q[0].pidx);
      check("out_first_part", out_first_part, exp_q[0].first);
      check("out_last_part", out_last_part, exp_q[0].lastp);
      check("out_last", out_last, exp_q[0].last);
    end
    if (out_valid && out_ready) begin
      b.frag  = out_frag_part;
      b.index = out_index;
      b.pidx  = out_part_idx;
      b.first = out_first_part;
      b.lastp = out_last_part;
      b.last  = out_last;
      b.cyc   = cyc;
      log_q.push_back(b);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [FLB-1:0] frag, input logic [IC-1:0][IL-1:0] idx,
                       input logic [2:0] num);
    in_fragment     = frag;
    in_kmer_indices = idx;
    in_num_indices  = num;
    in_valid        = 1'b1;
    tick();
    in_valid = 1'b0;
    log_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_until(input int beats, input int budget, input bit toggle, input string name);
    for (int o = 1; o <= budget; o++) begin
      if (log_q.size() >= beats) break;
      out_ready = toggle ? (o % 2 == 1) : 1'b1;
      tick();
    end
    check({name, "_beats"}, log_q.size(), beats);
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, out_valid, 1'b0);
    check({name, "_ready"}, in_ready, 1'b1);
    check({name, "_done"}, done, 1'b0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_frag"}, out_frag_part, 4'h0);
    check({name, "_index"}, out_index, 8'h00);
    check({name, "_pidx"}, out_part_idx, 2'd0);
    check({name, "_first"}, out_first_part, 1'b0);
    check({name, "_lastp"}, out_last_part, 1'b0);
    check({name, "_last"}, out_last, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_fragment = '0; in_kmer_indices = '0; in_num_indices = 3'd0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("RST0");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Full-rate batch of four indices.
    offer(16'hE4B1, {8'd40, 8'd30, 8'd20, 8'd10}, 3'd4);
    run_until(16, 40, 1'b0, "A");
    if (log_q.size() >= 16) begin
      check("A_p0", log_q[0].frag, 4'h1);
      check("A_p1", log_q[1].frag, 4'hB);
      check("A_p2", log_q[2].frag, 4'h4);
      check("A_p3", log_q[3].frag, 4'hE);
      check("A_idx1", log_q[4].index, 8'd20);
      check("A_idx3", log_q[15].index, 8'd40);
      check("A_last14", log_q[14].last, 1'b0);
      check("A_last15", log_q[15].last, 1'b1);
      check("A_lat", log_q[0].cyc - acc_cyc, 1);
      check("A_end", log_q[15].cyc - acc_cyc, 16);
    end
    check("A_done_cnt", done_cnt, 1);
    check("A_done_at", done_cyc - acc_cyc, 17);

    // Same batch with out_ready toggling every cycle.
    offer(16'hE4B1, {8'd40, 8'd30, 8'd20, 8'd10}, 3'd4);
    run_until(16, 60, 1'b1, "B");
    if (log_q.size() >= 16) begin
      check("B_p1", log_q[5].frag, 4'hB);
      check("B_gap", log_q[1].cyc - log_q[0].cyc, 2);
      check("B_end", log_q[15].cyc - acc_cyc, 31);
    end
    check("B_done_at", done_cyc - acc_cyc, 32);

    // Second batch waiting at the final handshake of a one-index batch.
    offer(16'h1234, {8'd0, 8'd0, 8'd0, 8'd5}, 3'd1);
    in_fragment = 16'hABCD; in_kmer_indices = {8'd0, 8'd0, 8'd8, 8'd7}; in_num_indices = 3'd2;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    run_until(12, 30, 1'b0, "C");
    if (log_q.size() >= 12) begin
      check("C_b1_p0", log_q[0].frag, 4'h4);
      check("C_b1_last", log_q[3].last, 1'b1);
      check("C_b2_idx", log_q[4].index, 8'd7);
      check("C_b2_p0", log_q[4].frag, 4'hD);
      check("C_nobubble", log_q[4].cyc - log_q[3].cyc, 1);
      check("C_b2_last", log_q[11].last, 1'b1);
      check("C_b2_lidx", log_q[11].index, 8'd8);
    end
    check("C_done_cnt", done_cnt, 2);

    // Empty batch, then two indices, then an oversized count.
    offer(16'h0F0F, {8'd1, 8'd2, 8'd3, 8'd4}, 3'd0);
    tick();
    check("D_nobeats", log_q.size(), 0);
    check("D_done_cnt", done_cnt, 1);
    check("D_done_at", done_cyc - acc_cyc, 1);
    offer(16'h5A3C, {8'd44, 8'd33, 8'd22, 8'd11}, 3'd2);
    run_until(8, 30, 1'b0, "D2");
    if (log_q.size() >= 8) begin
      check("D2_l3_last", log_q[3].last, 1'b0);
      check("D2_l3_lastp", log_q[3].lastp, 1'b1);
      check("D2_l7_last", log_q[7].last, 1'b1);
      check("D2_l7_idx", log_q[7].index, 8'd22);
      check("D2_l7_pidx", log_q[7].pidx, 2'd3);
    end
    offer(16'h8421, {8'd4, 8'd3, 8'd2, 8'd1}, 3'd7);
    run_until(16, 40, 1'b0, "SAT");
    if (log_q.size() >= 16) begin
      check("SAT_idx", log_q[15].index, 8'd4);
      check("SAT_last", log_q[15].last, 1'b1);
    end

    // Abort at the sixth beat while a new batch is offered.
    offer(16'hE4B1, {8'd40, 8'd30, 8'd20, 8'd10}, 3'd4);
    repeat (5) tick();
    abort = 1'b1; in_valid = 1'b1; in_num_indices = 3'd1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("E_valid", out_valid, 1'b0);
    check("E_busy", busy, 1'b0);
    tick();
    tick();
    check("E_beats", log_q.size(), 6);
    check("E_done", done_cnt, 0);
    check("E_noaccept", out_valid, 1'b0);

    // Asynchronous reset in the middle of a batch.
    offer(16'hE4B1, {8'd40, 8'd30, 8'd20, 8'd10}, 3'd4);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("RSTM");
    #10 rst_n = 1'b1;
    tick();
    tick();
    check("RSTM_nodone", done_cnt, 0);
    check("RSTM_idle", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
